// File: rtl/csr_file_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, op encodings,
// status/interrupt bit positions and trap cause codes.
package csr_file_pkg;

   typedef enum logic [1:0] {
      CSR_NONE  = 2'b00,
      CSR_WRITE = 2'b01,
      CSR_SET   = 2'b10,
      CSR_CLEAR = 2'b11
   } csr_op_e;

   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MIE       = 12'h304;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MTVAL     = 12'h343;
   localparam logic [11:0] ADDR_MIP       = 12'h344;
   localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
   localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
   localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
   localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

   localparam int unsigned MSTATUS_MIE    = 3;
   localparam int unsigned MSTATUS_MPIE   = 7;
   localparam int unsigned MSTATUS_MPP_LO = 11;
   localparam int unsigned MIE_MTIE       = 7;
   localparam int unsigned MIP_MTIP       = 7;

   localparam int unsigned IRQ_CAUSE_MTI  = 7;
   localparam int unsigned EXC_ILLEGAL    = 2;
   localparam int unsigned EXC_BREAKPOINT = 3;
   localparam int unsigned EXC_ECALL_M    = 11;

   function automatic logic [63:0] csr_apply(csr_op_e op, logic [63:0] old_v, logic [63:0] wdata);
      case (op)
         CSR_WRITE: return wdata;
         CSR_SET:   return old_v | wdata;
         CSR_CLEAR: return old_v & ~wdata;
         default:   return old_v;
      endcase
   endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter with independent half-word write ports;
// any write in a cycle replaces that cycle's increment.
module csr_counter64 (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wdata_lo,
   input  logic [31:0] wdata_hi,
   output logic [63:0] value
);

   logic [63:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (wr_lo || wr_hi) begin
         // the unwritten half keeps its value and receives no carry
         if (wr_lo) cnt[31:0]  <= wdata_lo;
         if (wr_hi) cnt[63:32] <= wdata_hi;
      end else if (inc) begin
         cnt <= cnt + 64'd1;
      end
   end

   assign value = cnt;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: Zicsr accesses, trap/mret state, timer interrupt
// entry and the mcycle/minstret counters.
module csr_file
   import csr_file_pkg::*;
#(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned HART_ID      = 0,
   parameter int unsigned HAS_COUNTERS = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      csr_op,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   input  logic            trap_req,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_tval,
   input  logic            mret,
   input  logic            instret,
   input  logic            irq_timer,
   output logic            irq_take,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   localparam bit CNT_EN  = (HAS_COUNTERS != 0);
   localparam bit CNTH_EN = CNT_EN && (XLEN == 32);
   localparam logic [XLEN-1:0] PC_MASK    = {{(XLEN-2){1'b1}}, 2'b00};
   localparam logic [XLEN-1:0] IRQ_MCAUSE = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(IRQ_CAUSE_MTI);
   localparam logic [XLEN-1:0] IRQ_VEC_OFS = XLEN'(4 * IRQ_CAUSE_MTI);

   csr_op_e op;
   logic st_mie, st_mpie, mtie;
   logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval;
   logic [63:0] mcycle, minstret;
   logic [XLEN-1:0] wval, tvec_base;
   logic [63:0] wval64;
   logic implemented, csr_we;
   logic cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;
   logic [31:0] cnt_wdata_hi;

   assign op = csr_op_e'(csr_op);

   always_comb begin
      csr_rdata   = '0;
      implemented = 1'b1;
      case (csr_addr)
         ADDR_MSTATUS: begin
            csr_rdata[MSTATUS_MPP_LO +: 2] = 2'b11;
            csr_rdata[MSTATUS_MIE]         = st_mie;
            csr_rdata[MSTATUS_MPIE]        = st_mpie;
         end
         ADDR_MIE:       csr_rdata[MIE_MTIE] = mtie;
         ADDR_MTVEC:     csr_rdata = mtvec;
         ADDR_MSCRATCH:  csr_rdata = mscratch;
         ADDR_MEPC:      csr_rdata = mepc;
         ADDR_MCAUSE:    csr_rdata = mcause;
         ADDR_MTVAL:     csr_rdata = mtval;
         ADDR_MIP:       csr_rdata[MIP_MTIP] = irq_timer;
         ADDR_MHARTID:   csr_rdata = XLEN'(HART_ID);
         ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID: csr_rdata = '0;
         ADDR_MCYCLE:    if (CNT_EN)  csr_rdata = XLEN'(mcycle);           else implemented = 1'b0;
         ADDR_MINSTRET:  if (CNT_EN)  csr_rdata = XLEN'(minstret);         else implemented = 1'b0;
         ADDR_MCYCLEH:   if (CNTH_EN) csr_rdata = XLEN'(mcycle[63:32]);    else implemented = 1'b0;
         ADDR_MINSTRETH: if (CNTH_EN) csr_rdata = XLEN'(minstret[63:32]);  else implemented = 1'b0;
         default:        implemented = 1'b0;
      endcase
   end

   assign csr_illegal = (op != CSR_NONE) &&
                        (!implemented || (csr_addr[11:10] == 2'b11) || (csr_addr == ADDR_MIP));

   assign irq_take = st_mie & mtie & irq_timer & ~trap_req & ~mret;
   assign csr_we   = (op != CSR_NONE) && !csr_illegal && !trap_req && !irq_take && !mret;

   assign wval64 = csr_apply(op, 64'(csr_rdata), 64'(csr_wdata));
   assign wval   = XLEN'(wval64);

   assign tvec_base      = mtvec & PC_MASK;
   assign redirect_valid = trap_req | irq_take | mret;

   always_comb begin
      redirect_pc = '0;
      if (trap_req)
         redirect_pc = tvec_base;
      else if (irq_take)
         redirect_pc = (mtvec[1:0] == 2'b01) ? tvec_base + IRQ_VEC_OFS : tvec_base;
      else if (mret)
         redirect_pc = mepc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_mie   <= 1'b0;
         st_mpie  <= 1'b0;
         mtie     <= 1'b0;
         mtvec    <= '0;
         mscratch <= '0;
         mepc     <= '0;
         mcause   <= '0;
         mtval    <= '0;
      end else if (trap_req || irq_take) begin
         mepc    <= trap_pc & PC_MASK;
         mcause  <= trap_req ? trap_cause : IRQ_MCAUSE;
         mtval   <= trap_req ? trap_tval : '0;
         st_mpie <= st_mie;
         st_mie  <= 1'b0;
      end else if (mret) begin
         st_mie  <= st_mpie;
         st_mpie <= 1'b1;
      end else if (csr_we) begin
         case (csr_addr)
            ADDR_MSTATUS: begin
               st_mie  <= wval[MSTATUS_MIE];
               st_mpie <= wval[MSTATUS_MPIE];
            end
            ADDR_MIE:      mtie     <= wval[MIE_MTIE];
            // unsupported MODE encodings (10, 11) keep the previous mode
            ADDR_MTVEC:    mtvec    <= wval[1] ? {wval[XLEN-1:2], mtvec[1:0]} : wval;
            ADDR_MSCRATCH: mscratch <= wval;
            ADDR_MEPC:     mepc     <= wval & PC_MASK;
            ADDR_MCAUSE:   mcause   <= wval;
            ADDR_MTVAL:    mtval    <= wval;
            default: ;
         endcase
      end
   end

   // on RV64 one access covers the whole counter; on RV32 the H alias supplies the top half
   assign cnt_wdata_hi = (XLEN == 64) ? wval64[63:32] : wval64[31:0];
   assign cyc_wr_lo = csr_we && (csr_addr == ADDR_MCYCLE);
   assign cyc_wr_hi = csr_we && ((csr_addr == ADDR_MCYCLEH) || ((XLEN == 64) && (csr_addr == ADDR_MCYCLE)));
   assign ins_wr_lo = csr_we && (csr_addr == ADDR_MINSTRET);
   assign ins_wr_hi = csr_we && ((csr_addr == ADDR_MINSTRETH) || ((XLEN == 64) && (csr_addr == ADDR_MINSTRET)));

   generate
      if (CNT_EN) begin : g_cnt
         csr_counter64 u_mcycle (
            .clk      (clk),
            .rst      (rst),
            .inc      (1'b1),
            .wr_lo    (cyc_wr_lo),
            .wr_hi    (cyc_wr_hi),
            .wdata_lo (wval64[31:0]),
            .wdata_hi (cnt_wdata_hi),
            .value    (mcycle)
         );
         csr_counter64 u_minstret (
            .clk      (clk),
            .rst      (rst),
            .inc      (instret),
            .wr_lo    (ins_wr_lo),
            .wr_hi    (ins_wr_hi),
            .wdata_lo (wval64[31:0]),
            .wdata_hi (cnt_wdata_hi),
            .value    (minstret)
         );
      end else begin : g_nocnt
         assign mcycle   = '0;
         assign minstret = '0;
      end
   endgenerate

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: table of CSR accesses plus hand-written
// trap, mret, interrupt, counter and reset sequences, checked via a scoreboard.
module tb_csr_file;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        trap_req;
   logic [31:0] trap_cause, trap_pc, trap_tval;
   logic        mret, instret, irq_timer;
   logic        irq_take, redirect_valid;
   logic [31:0] redirect_pc;

   csr_file #(.XLEN(32), .HART_ID(5), .HAS_COUNTERS(1)) dut (
      .clk            (clk),
      .rst            (rst),
      .csr_op         (csr_op),
      .csr_addr       (csr_addr),
      .csr_wdata      (csr_wdata),
      .csr_rdata      (csr_rdata),
      .csr_illegal    (csr_illegal),
      .trap_req       (trap_req),
      .trap_cause     (trap_cause),
      .trap_pc        (trap_pc),
      .trap_tval      (trap_tval),
      .mret           (mret),
      .instret        (instret),
      .irq_timer      (irq_timer),
      .irq_take       (irq_take),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   localparam logic [1:0] N = 2'b00, W = 2'b01, S = 2'b10, C = 2'b11;
   localparam int unsigned K_RDATA = 0, K_ILL = 1, K_RV = 2, K_RPC = 3, K_IRQ = 4;

   typedef struct {
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_ill;
   } vec_t;

   typedef struct {
      string       name;
      int unsigned kind;
      logic [31:0] exp;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   task automatic idle();
      csr_op = N; csr_addr = '0; csr_wdata = '0;
      trap_req = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
      mret = 1'b0; instret = 1'b0; irq_timer = 1'b0;
   endtask

   task automatic acc(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
      csr_op = op; csr_addr = addr; csr_wdata = wd;
   endtask

   task automatic expect_out(input string name, input int unsigned kind, input logic [31:0] e);
      exp_t x;
      x.name = name; x.kind = kind; x.exp = e;
      sb.push_back(x);
   endtask

   // compare everything queued for this cycle away from the edge, then advance
   task automatic tick();
      exp_t x;
      logic [31:0] act;
      @(negedge clk);
      while (sb.size() > 0) begin
         x = sb.pop_front();
         case (x.kind)
            K_RDATA: act = csr_rdata;
            K_ILL:   act = {31'd0, csr_illegal};
            K_RV:    act = {31'd0, redirect_valid};
            K_RPC:   act = redirect_pc;
            default: act = {31'd0, irq_take};
         endcase
         checks++;
         if (act !== x.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", x.name, act, x.exp);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] e);
      acc(N, addr, '0);
      expect_out(name, K_RDATA, e);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs.push_back('{N, 12'h300, 32'h0,        32'h0000_1800, 1'b0});
      vecs.push_back('{N, 12'hF14, 32'h0,        32'h0000_0005, 1'b0});
      vecs.push_back('{N, 12'h305, 32'h0,        32'h0000_0000, 1'b0});
      vecs.push_back('{W, 12'h305, 32'h80000101, 32'h0000_0000, 1'b0});
      vecs.push_back('{S, 12'h305, 32'h2,        32'h8000_0101, 1'b0});
      vecs.push_back('{C, 12'h305, 32'h100,      32'h8000_0101, 1'b0});
      vecs.push_back('{N, 12'h305, 32'h0,        32'h8000_0001, 1'b0});
      vecs.push_back('{W, 12'h305, 32'h80000003, 32'h8000_0001, 1'b0});
      vecs.push_back('{N, 12'h305, 32'h0,        32'h8000_0001, 1'b0});
      vecs.push_back('{W, 12'h340, 32'hDEADBEEF, 32'h0000_0000, 1'b0});
      vecs.push_back('{S, 12'h340, 32'h10,       32'hDEAD_BEEF, 1'b0});
      vecs.push_back('{C, 12'h340, 32'hF,        32'hDEAD_BEFF, 1'b0});
      vecs.push_back('{N, 12'h340, 32'h0,        32'hDEAD_BEF0, 1'b0});
      vecs.push_back('{W, 12'h300, 32'hFFFFFFFF, 32'h0000_1800, 1'b0});
      vecs.push_back('{C, 12'h300, 32'h8,        32'h0000_1888, 1'b0});
      vecs.push_back('{N, 12'h300, 32'h0,        32'h0000_1880, 1'b0});
      vecs.push_back('{W, 12'h304, 32'hFFFFFFFF, 32'h0000_0000, 1'b0});
      vecs.push_back('{N, 12'h304, 32'h0,        32'h0000_0080, 1'b0});
      vecs.push_back('{W, 12'h341, 32'h12345677, 32'h0000_0000, 1'b0});
      vecs.push_back('{N, 12'h341, 32'h0,        32'h1234_5674, 1'b0});
      vecs.push_back('{W, 12'hF14, 32'h9,        32'h0000_0005, 1'b1});
      vecs.push_back('{W, 12'h344, 32'h80,       32'h0000_0000, 1'b1});
      vecs.push_back('{N, 12'hF14, 32'h0,        32'h0000_0005, 1'b0});
      vecs.push_back('{W, 12'h7C0, 32'h1,        32'h0000_0000, 1'b1});
      vecs.push_back('{N, 12'h7C0, 32'h0,        32'h0000_0000, 1'b0});
      vecs.push_back('{S, 12'hF11, 32'h0,        32'h0000_0000, 1'b1});
      vecs.push_back('{W, 12'h343, 32'hA5A5,     32'h0000_0000, 1'b0});
      vecs.push_back('{N, 12'h343, 32'h0,        32'h0000_A5A5, 1'b0});
      vecs.push_back('{W, 12'h342, 32'h2,        32'h0000_0000, 1'b0});
      vecs.push_back('{N, 12'h342, 32'h0,        32'h0000_0002, 1'b0});
      vecs.push_back('{W, 12'h300, 32'h0,        32'h0000_1880, 1'b0});
      vecs.push_back('{W, 12'h304, 32'h0,        32'h0000_0080, 1'b0});
      vecs.push_back('{N, 12'h304, 32'h0,        32'h0000_0000, 1'b0});

      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      expect_out("reset_redirect_valid", K_RV, 32'd0);
      expect_out("reset_irq_take", K_IRQ, 32'd0);
      expect_out("reset_mcycle", K_RDATA, 32'd0);
      acc(N, 12'hB00, '0);
      tick();

      for (int i = 0; i < vecs.size(); i++) begin
         acc(vecs[i].op, vecs[i].addr, vecs[i].wdata);
         expect_out($sformatf("vec%0d_rdata", i), K_RDATA, vecs[i].exp_rdata);
         expect_out($sformatf("vec%0d_illegal", i), K_ILL, {31'd0, vecs[i].exp_ill});
         tick();
      end

      // synchronous exception with a competing CSR write that must be dropped
      acc(W, 12'h305, 32'h80000000); tick();
      acc(W, 12'h300, 32'h8);        tick();
      acc(W, 12'h340, 32'h0);
      trap_req = 1'b1; trap_cause = 32'd11; trap_pc = 32'h80000010; trap_tval = 32'h55;
      expect_out("trap_rv", K_RV, 32'd1);
      expect_out("trap_rpc", K_RPC, 32'h80000000);
      expect_out("trap_irq", K_IRQ, 32'd0);
      tick();
      idle();
      rd("trap_mepc", 12'h341, 32'h80000010);
      rd("trap_mcause", 12'h342, 32'h0000000B);
      rd("trap_mtval", 12'h343, 32'h00000055);
      rd("trap_mscratch_kept", 12'h340, 32'hDEADBEF0);
      rd("trap_mstatus", 12'h300, 32'h00001880);

      // mret, again with a CSR write that loses priority
      acc(W, 12'h340, 32'h1);
      mret = 1'b1;
      expect_out("mret_rv", K_RV, 32'd1);
      expect_out("mret_rpc", K_RPC, 32'h80000010);
      tick();
      idle();
      rd("mret_mstatus", 12'h300, 32'h00001888);
      rd("mret_mscratch_kept", 12'h340, 32'hDEADBEF0);

      // vectored timer interrupt
      acc(W, 12'h304, 32'h80);       tick();
      acc(W, 12'h305, 32'h80000001); tick();
      acc(N, 12'h344, '0);
      irq_timer = 1'b1; trap_pc = 32'h80000040; trap_tval = 32'hDEAD;
      expect_out("irq_mip", K_RDATA, 32'h80);
      expect_out("irq_take", K_IRQ, 32'd1);
      expect_out("irq_rv", K_RV, 32'd1);
      expect_out("irq_rpc", K_RPC, 32'h8000001C);
      tick();
      trap_pc = '0; trap_tval = '0;
      expect_out("irq_masked_after", K_IRQ, 32'd0);
      expect_out("irq_rv_after", K_RV, 32'd0);
      rd("irq_mcause", 12'h342, 32'h80000007);
      irq_timer = 1'b0;
      rd("irq_mepc", 12'h341, 32'h80000040);
      rd("irq_mtval", 12'h343, 32'h0);
      rd("irq_mstatus", 12'h300, 32'h00001880);

      // exception beats a pending interrupt and uses the base vector
      acc(W, 12'h300, 32'h8); tick();
      idle();
      irq_timer = 1'b1; trap_req = 1'b1; trap_cause = 32'd3; trap_pc = 32'h80000080;
      expect_out("prio_irq", K_IRQ, 32'd0);
      expect_out("prio_rv", K_RV, 32'd1);
      expect_out("prio_rpc", K_RPC, 32'h80000000);
      tick();
      idle();
      rd("prio_mcause", 12'h342, 32'h3);
      rd("prio_mstatus", 12'h300, 32'h00001880);

      // 64-bit wrap of mcycle
      acc(W, 12'hB00, 32'hFFFFFFFF); tick();
      acc(W, 12'hB80, 32'hFFFFFFFF); tick();
      rd("mcycle_allones_lo", 12'hB00, 32'hFFFFFFFF);
      rd("mcycle_wrap_lo", 12'hB00, 32'h0);
      rd("mcycle_wrap_hi", 12'hB80, 32'h0);
      rd("mcycle_count_on", 12'hB00, 32'h2);

      // write overrides increment
      acc(W, 12'hB00, 32'h100); tick();
      rd("mcycle_written", 12'hB00, 32'h100);
      rd("mcycle_next", 12'hB00, 32'h101);

      // minstret
      acc(W, 12'hB02, 32'h0); instret = 1'b1; tick();
      for (int i = 0; i < 3; i++) begin
         acc(N, 12'hB02, '0);
         expect_out($sformatf("minstret_run%0d", i), K_RDATA, i);
         tick();
      end
      instret = 1'b0;
      rd("minstret_count", 12'hB02, 32'd3);
      acc(W, 12'hB82, 32'h7); instret = 1'b1; tick();
      instret = 1'b0;
      rd("minstreth_written", 12'hB82, 32'h7);
      rd("minstret_lo_kept", 12'hB02, 32'd3);

      // reset wins over a simultaneous trap and write
      acc(W, 12'h340, 32'h1);
      trap_req = 1'b1; trap_cause = 32'd2; trap_pc = 32'h80000100;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      expect_out("rst2_rv", K_RV, 32'd0);
      expect_out("rst2_irq", K_IRQ, 32'd0);
      rd("rst2_mcycle", 12'hB00, 32'h0);
      rd("rst2_mstatus", 12'h300, 32'h00001800);
      rd("rst2_mscratch", 12'h340, 32'h0);
      rd("rst2_mepc", 12'h341, 32'h0);
      rd("rst2_mtvec", 12'h305, 32'h0);
      rd("rst2_minstret", 12'hB02, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
